fpga_spi_reg_slave: RTL

//   SPI responder (slave) in FPGA fabric. It is the far end of the PULPissimo SPI master (spim_sck/csn/sdio0/sdio1).

---
 rtl/fpga_spi_reg_slave.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fpga_spi_reg_slave.sv
// SPI mode-0 responder exposing a byte register file to an SPI master.
// Pins are oversampled in the clk_i domain; the fabric side gets a host port.
module fpga_spi_reg_slave #(
    parameter int         DEPTH       = 16,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] ID_BYTE     = 8'hA7,
    localparam int        AW          = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          sck_i,
    input  logic          csn_i,
    input  logic          mosi_i,
    output logic          miso_o,
    output logic          miso_oe_o,
    output logic          busy_o,
    input  logic [AW-1:0] host_addr_i,
    input  logic          host_we_i,
    input  logic [7:0]    host_wdata_i,
    output logic [7:0]    host_rdata_o,
    output logic          spi_wr_o,
    output logic [AW-1:0] spi_addr_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_IDRD,
        S_IGNORE
    } state_e;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] csn_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_dly_q;
    logic                   csn_dly_q;
    logic                   armed_q;

    state_e        state_q;
    logic          wr_mode_q;
    logic [AW-1:0] ptr_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    rx_sh_q;
    logic [7:0]    tx_sh_q;
    logic [7:0]    regs_q [DEPTH];

    logic       sck_s;
    logic       csn_s;
    logic       mosi_s;
    logic       sck_rise;
    logic       sck_fall;
    logic       csn_fall;
    logic [7:0] rx_byte;
    logic [7:0] tx_load;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign csn_s    = csn_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_dly_q;
    assign sck_fall = ~sck_s & sck_dly_q;
    // csn_dly_q is only ever 1 from a real high csn, so a reset mid-frame
    // cannot fake a falling edge when the synchronizer refills.
    assign csn_fall = csn_dly_q & ~csn_s;
    assign rx_byte  = {rx_sh_q[6:0], mosi_s};

    assign host_rdata_o = regs_q[host_addr_i];

    always_comb begin
        tx_load = 8'h00;
        if (state_q == S_RDATA) begin
            tx_load = regs_q[ptr_q];
        end else if (state_q == S_IDRD) begin
            tx_load = ID_BYTE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_sync_q  <= '0;
            csn_sync_q  <= '0;
            mosi_sync_q <= '0;
            sck_dly_q   <= 1'b0;
            csn_dly_q   <= 1'b0;
            armed_q     <= 1'b0;
            state_q     <= S_IDLE;
            wr_mode_q   <= 1'b0;
            ptr_q       <= '0;
            bit_cnt_q   <= 3'd0;
            rx_sh_q     <= 8'h00;
            tx_sh_q     <= 8'h00;
            miso_o      <= 1'b0;
            miso_oe_o   <= 1'b0;
            busy_o      <= 1'b0;
            spi_wr_o    <= 1'b0;
            spi_addr_o  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], csn_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sck_dly_q   <= sck_s;
            csn_dly_q   <= csn_s;
            busy_o      <= armed_q & ~csn_s;
            spi_wr_o    <= 1'b0;
            if (csn_s) begin
                armed_q <= 1'b1;
            end
            if (host_we_i) begin
                regs_q[host_addr_i] <= host_wdata_i;
            end
            if (csn_s) begin
                state_q   <= S_IDLE;
                bit_cnt_q <= 3'd0;
                miso_oe_o <= 1'b0;
            end else if (csn_fall) begin
                state_q   <= S_CMD;
                bit_cnt_q <= 3'd0;
                miso_oe_o <= 1'b1;
                tx_sh_q   <= 8'h00;
                miso_o    <= 1'b0;
            end else if (state_q != S_IDLE) begin
                if (sck_rise) begin
                    rx_sh_q   <= rx_byte;
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        unique case (state_q)
                            S_CMD: begin
                                unique case (rx_byte)
                                    8'h02: begin
                                        state_q   <= S_ADDR;
                                        wr_mode_q <= 1'b1;
                                    end
                                    8'h03: begin
                                        state_q   <= S_ADDR;
                                        wr_mode_q <= 1'b0;
                                    end
                                    8'h9F:   state_q <= S_IDRD;
                                    default: state_q <= S_IGNORE;
                                endcase
                            end
                            S_ADDR: begin
                                ptr_q   <= rx_byte[AW-1:0];
                                state_q <= wr_mode_q ? S_WDATA : S_RDATA;
                            end
                            S_WDATA: begin
                                // Placed after the host write so SPI wins a collision.
                                regs_q[ptr_q] <= rx_byte;
                                spi_wr_o      <= 1'b1;
                                spi_addr_o    <= ptr_q;
                                ptr_q         <= ptr_q + AW'(1);
                            end
                            S_RDATA: ptr_q <= ptr_q + AW'(1);
                            default: ;
                        endcase
                    end
                end else if (sck_fall) begin
                    if (bit_cnt_q == 3'd0) begin
                        tx_sh_q <= tx_load;
                        miso_o  <= tx_load[7];
                    end else begin
                        tx_sh_q <= {tx_sh_q[6:0], 1'b0};
                        miso_o  <= tx_sh_q[6];
                    end
                end
            end
        end
    end

endmodule
